ov7670_ball_tracker: RTL

Per-frame colour-blob statistics engine that sits directly downstream of the OV7670 capture stage on the camera pixel clock. It consumes the full-resolution RGB565 pixel stream (`dout`/`we`) together with `vsync`. It classifies each pixel against a programmable RGB window and accumulates the match count, the coordinate sums and a bounding box. At each frame end it publishes one result record through a valid/ack handshake to the AXI/software side, which computes the centroid.

---
 rtl/ov7670_pkg.sv | 42 ++++
 rtl/rgb565_classifier.sv | 42 ++++
 rtl/ov7670_ball_tracker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
`default_nettype none
// ==========================================================================
// ov7670_pkg: frame geometry, widths, RGB565 field slices, states. rev 1.0
// ==========================================================================
package ov7670_pkg;

  localparam int X_MAX = 640;
  localparam int Y_MAX = 480;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CNT_W = 19;
  localparam int SUM_W = 28;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    BLANK     = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] r_min;
    logic [4:0] r_max;
    logic [5:0] g_min;
    logic [5:0] g_max;
    logic [4:0] b_min;
    logic [4:0] b_max;
  } thr_t;

  function automatic logic [4:0] pix_r(input logic [15:0] p);
    return p[15:11];
  endfunction

  function automatic logic [5:0] pix_g(input logic [15:0] p);
    return p[10:5];
  endfunction

  function automatic logic [4:0] pix_b(input logic [15:0] p);
    return p[4:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb565_classifier.sv
`default_nettype none
// ==========================================================================
// rgb565_classifier: registered RGB window compare (pipeline stage 1). rev 1.0
// ==========================================================================
module rgb565_classifier
  import ov7670_pkg::*;
(
  input  logic           pclk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [15:0]    pixel,
  input  thr_t           thr,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  output logic           hit,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out
);

  logic in_win;

  // An inverted window (min > max) can never satisfy both bounds.
  always_comb begin
    in_win = (pix_r(pixel) >= thr.r_min) && (pix_r(pixel) <= thr.r_max) &&
             (pix_g(pixel) >= thr.g_min) && (pix_g(pixel) <= thr.g_max) &&
             (pix_b(pixel) >= thr.b_min) && (pix_b(pixel) <= thr.b_max);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hit   <= 1'b0;
      x_out <= '0;
      y_out <= '0;
    end else begin
      hit   <= in_valid && in_win;
      x_out <= x_in;
      y_out <= y_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ov7670_ball_tracker.sv
`default_nettype none
// ==========================================================================
// ov7670_ball_tracker: per-frame colour-blob count/sums/bounding box. rev 1.0
// ==========================================================================
module ov7670_ball_tracker
  import ov7670_pkg::state_t, ov7670_pkg::WAIT_SYNC, ov7670_pkg::BLANK, ov7670_pkg::ACTIVE,
         ov7670_pkg::thr_t, ov7670_pkg::X_W, ov7670_pkg::Y_W, ov7670_pkg::CNT_W, ov7670_pkg::SUM_W;
#(
  parameter int X_MAX = ov7670_pkg::X_MAX,
  parameter int Y_MAX = ov7670_pkg::Y_MAX
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             pix_we,
  input  logic [15:0]      pix_data,
  input  logic [4:0]       r_min,
  input  logic [4:0]       r_max,
  input  logic [5:0]       g_min,
  input  logic [5:0]       g_max,
  input  logic [4:0]       b_min,
  input  logic [4:0]       b_max,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [CNT_W-1:0] res_count,
  output logic [SUM_W-1:0] res_sum_x,
  output logic [SUM_W-1:0] res_sum_y,
  output logic [X_W-1:0]   res_min_x,
  output logic [X_W-1:0]   res_max_x,
  output logic [Y_W-1:0]   res_min_y,
  output logic [Y_W-1:0]   res_max_y,
  output logic             res_overrun
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
  localparam logic [Y_W-1:0] Y_END  = Y_W'(Y_MAX);

  state_t           state;
  thr_t             thr_live, thr_shadow, thr_use;
  logic             start, strobe, keep;
  logic [X_W-1:0]   x, x_cur, s1_x, min_x, max_x;
  logic [Y_W-1:0]   y, y_cur, s1_y, min_y, max_y;
  logic             s1_hit, pub_d1, pub_d2;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] sum_x, sum_y;

  // The first active cycle sees coordinates (0,0) and the live window, since
  // the counters and shadow registers only take their new values at its edge.
  assign thr_live = {r_min, r_max, g_min, g_max, b_min, b_max};
  assign start    = (state == BLANK) && !vsync;
  assign strobe   = pix_we && !vsync && (state != WAIT_SYNC);
  assign x_cur    = start ? '0 : x;
  assign y_cur    = start ? '0 : y;
  assign keep     = strobe && (y_cur != Y_END);
  assign thr_use  = start ? thr_live : thr_shadow;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SYNC;
      thr_shadow <= '0;
      x          <= '0;
      y          <= '0;
      pub_d1     <= 1'b0;
      pub_d2     <= 1'b0;
    end else begin
      pub_d1 <= (state == ACTIVE) && vsync;
      pub_d2 <= pub_d1;
      case (state)
        WAIT_SYNC: if (vsync) state <= BLANK;
        BLANK: begin
          if (!vsync) begin
            state      <= ACTIVE;
            thr_shadow <= thr_live;
          end
        end
        ACTIVE:    if (vsync) state <= BLANK;
        default:   state <= WAIT_SYNC;
      endcase
      if (strobe) begin
        if (x_cur == X_LAST) begin
          x <= '0;
          y <= (y_cur == Y_END) ? y_cur : y_cur + 1'b1;
        end else begin
          x <= x_cur + 1'b1;
          y <= y_cur;
        end
      end else if (start) begin
        x <= '0;
        y <= '0;
      end
    end
  end

  rgb565_classifier u_classify (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .in_valid (keep),
    .pixel    (pix_data),
    .thr      (thr_use),
    .x_in     (x_cur),
    .y_in     (y_cur),
    .hit      (s1_hit),
    .x_out    (s1_x),
    .y_out    (s1_y)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n || start) begin
      count <= '0;
      sum_x <= '0;
      sum_y <= '0;
      min_x <= '1;
      min_y <= '1;
      max_x <= '0;
      max_y <= '0;
    end else if (s1_hit) begin
      count <= count + 1'b1;
      sum_x <= sum_x + SUM_W'(s1_x);
      sum_y <= sum_y + SUM_W'(s1_y);
      if (s1_x < min_x) min_x <= s1_x;
      if (s1_x > max_x) max_x <= s1_x;
      if (s1_y < min_y) min_y <= s1_y;
      if (s1_y > max_y) max_y <= s1_y;
    end
  end

  // An ack in the publish cycle retires the old record, so no overrun.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_overrun <= 1'b0;
      res_count   <= '0;
      res_sum_x   <= '0;
      res_sum_y   <= '0;
      res_min_x   <= '0;
      res_max_x   <= '0;
      res_min_y   <= '0;
      res_max_y   <= '0;
    end else if (pub_d2) begin
      res_valid <= 1'b1;
      res_count <= count;
      res_sum_x <= sum_x;
      res_sum_y <= sum_y;
      res_min_x <= min_x;
      res_max_x <= max_x;
      res_min_y <= min_y;
      res_max_y <= max_y;
      if (res_valid && !res_ack) res_overrun <= 1'b1;
    end else if (res_valid && res_ack) begin
      res_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
